scanline_fetch_arbiter: RTL

SCANLINE_FETCH_ARBITER -- requirements
Module: scanline_fetch_arbiter

---
 rtl/scanline_fetch_arbiter.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/scanline_fetch_arbiter.sv
// Scanline fetch arbiter: fills a double-buffered line buffer with one display
// line per fetch trigger and interleaves single host memory transactions into
// the gaps. Display fetches always win over the host. One memory transaction at
// most is in flight at any time.
// Optional feature: define FETCH_STATS_EN to add stats_clr / underrun_count.
module scanline_fetch_arbiter #(
  parameter int unsigned FETCH_WORDS = 8,
  parameter int unsigned HEIGHT      = 600,
  parameter int unsigned ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           next_row,
  input  logic                           vsync_pulse,
  input  logic                           hblank,
  input  logic                           vblank,
  input  logic [ADDR_W-1:0]              base_addr,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_we,
  output logic [15:0]                    mem_wdata,
  input  logic                           mem_ack,
  input  logic [15:0]                    mem_rdata,
  input  logic                           host_valid,
  input  logic                           host_we,
  input  logic [ADDR_W-1:0]              host_addr,
  input  logic [15:0]                    host_wdata,
  output logic                           host_ready,
  output logic [15:0]                    host_rdata,
  output logic                           lb_we,
  output logic [$clog2(FETCH_WORDS)-1:0] lb_addr,
  output logic [15:0]                    lb_data,
  output logic                           lb_bank,
  output logic                           underrun
`ifdef FETCH_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [15:0]                    underrun_count
`endif
);

  localparam int unsigned WW = $clog2(FETCH_WORDS);
  localparam int unsigned LW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [LW-1:0] LastLine = LW'(HEIGHT - 1);
  localparam logic [WW-1:0] LastWord = WW'(FETCH_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StDisp, StHost, StDrain} state_e;

  state_e            state_q;
  logic [LW-1:0]     line_q, line_d;
  logic [WW-1:0]     word_q;
  logic              pend_q;
  logic              hblank_q;
  logic              rel_q;      // first cycle after reset release
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
  logic              host_ready_q;
  logic [15:0]       host_rdata_q;
  logic              lb_we_q;
  logic [WW-1:0]     lb_addr_q;
  logic [15:0]       lb_data_q;
  logic              lb_bank_q;
  logic              underrun_q;

  logic trig, ack_v, hb_fall, ur_evt;

  function automatic logic [ADDR_W-1:0] fetch_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [LW-1:0]     line,
                                                   input logic [WW-1:0]     word);
    return base + (ADDR_W'(line) << WW) + ADDR_W'(word);
  endfunction

  // Fetch trigger decode and the line number it moves to; vsync wins over next_row.
  always_comb begin
    trig   = 1'b0;
    line_d = line_q;
    if (vsync_pulse) begin
      trig   = 1'b1;
      line_d = '0;
    end else if (next_row && !vblank && (line_q < LastLine)) begin
      trig   = 1'b1;
      line_d = line_q + LW'(1);
    end
  end

  // Acks are only honoured for our own outstanding request, never right after reset.
  assign ack_v   = mem_ack & mem_req_q & ~rel_q;
  assign hb_fall = hblank_q & ~hblank;
  assign ur_evt  = (state_q == StDisp) & (trig | hb_fall);

  // Main FSM with registered memory, host and line-buffer outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      line_q       <= '0;
      word_q       <= '0;
      pend_q       <= 1'b0;
      hblank_q     <= 1'b0;
      rel_q        <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      host_ready_q <= 1'b0;
      host_rdata_q <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      lb_data_q    <= '0;
      lb_bank_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      rel_q        <= 1'b0;
      hblank_q     <= hblank;
      lb_we_q      <= 1'b0;
      host_ready_q <= 1'b0;

      // Every trigger starts a new line in the other bank, whatever the state.
      if (trig) begin
        line_q    <= line_d;
        lb_bank_q <= ~lb_bank_q;
        word_q    <= '0;
      end

      if (ur_evt) underrun_q <= 1'b1;
`ifdef FETCH_STATS_EN
      if (stats_clr) underrun_q <= 1'b0;
`endif

      unique case (state_q)
        StIdle: begin
          if (trig || pend_q) begin
            state_q    <= StDisp;
            pend_q     <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= fetch_addr(base_addr, line_d, '0);
          end else if (host_valid) begin
            state_q     <= StHost;
            mem_req_q   <= 1'b1;
            mem_we_q    <= host_we;
            mem_addr_q  <= host_addr;
            mem_wdata_q <= host_wdata;
          end
        end

        StDisp: begin
          if (trig) begin
            // Restart on the new line; an in-flight request must drain first.
            if (mem_req_q) begin
              if (ack_v) begin
                mem_req_q <= 1'b0;
              end else begin
                state_q <= StDrain;
                pend_q  <= 1'b1;
              end
            end else begin
              mem_req_q  <= 1'b1;
              mem_addr_q <= fetch_addr(base_addr, line_d, '0);
            end
          end else if (hb_fall) begin
            state_q <= StDrain;
            if (ack_v) mem_req_q <= 1'b0;
          end else if (ack_v) begin
            mem_req_q <= 1'b0;
            lb_we_q   <= 1'b1;
            lb_addr_q <= word_q;
            lb_data_q <= mem_rdata;
            word_q    <= word_q + WW'(1);
            if (word_q == LastWord) state_q <= StIdle;
          end else if (!mem_req_q) begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= fetch_addr(base_addr, line_q, word_q);
          end
        end

        StHost: begin
          if (trig) pend_q <= 1'b1;
          if (ack_v) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            host_ready_q <= 1'b1;
            pend_q       <= 1'b0;
            if (!mem_we_q) host_rdata_q <= mem_rdata;
            state_q <= (pend_q || trig) ? StDisp : StIdle;
          end
        end

        StDrain: begin
          if (trig) pend_q <= 1'b1;
          if (!mem_req_q || ack_v) begin
            mem_req_q <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] ur_cnt_q;

  // Saturating underrun event counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ur_cnt_q <= '0;
    end else if (stats_clr) begin
      ur_cnt_q <= '0;
    end else if (ur_evt && (ur_cnt_q != 16'hFFFF)) begin
      ur_cnt_q <= ur_cnt_q + 16'd1;
    end
  end

  assign underrun_count = ur_cnt_q;
`endif

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign host_ready = host_ready_q;
  assign host_rdata = host_rdata_q;
  assign lb_we      = lb_we_q;
  assign lb_addr    = lb_addr_q;
  assign lb_data    = lb_data_q;
  assign lb_bank    = lb_bank_q;
  assign underrun   = underrun_q;

endmodule
